// File: rtl/sp_loader.sv
// Serial-to-parallel word assembler feeding a loadable n-bit register (d/load).
// Optional even-parity check on each word, enabled by defining SP_LOADER_PARITY_EN.
module sp_loader #(
  parameter int n  = 4,
  parameter int CW = 8
) (
  input  logic          ck,
  input  logic          rst,
  input  logic          sin,
  input  logic          sval,
  input  logic          clr,
  output logic [n-1:0]  d,
  output logic          load,
  output logic          busy,
  output logic [CW-1:0] wcnt,
  output logic          perr
);

  localparam int BW = $clog2(n + 1);
  localparam logic [BW-1:0] LAST = BW'(n - 1);

`ifdef SP_LOADER_PARITY_EN
  typedef enum logic [1:0] {IDLE, SHIFT, PAR, LOAD} state_t;
  logic perr_q;
  assign perr = perr_q;
`else
  typedef enum logic [1:0] {IDLE, SHIFT, LOAD} state_t;
  assign perr = 1'b0;
`endif

  state_t          state;
  logic [n-1:0]    sr;
  logic [BW-1:0]   bc;
  logic [n-1:0]    shifted;
  logic [BW-1:0]   cnt_now;

  generate
    if (n == 1) begin : g_one
      assign shifted = sin;
    end else begin : g_wide
      assign shifted = {sr[n-2:0], sin};
    end
  endgenerate

  // Outside SHIFT a new word starts, so the accepted bit is bit 0 of the count.
  assign cnt_now = (state == SHIFT) ? bc : '0;

  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      sr    <= '0;
      bc    <= '0;
      d     <= '0;
      load  <= 1'b0;
      busy  <= 1'b0;
      wcnt  <= '0;
`ifdef SP_LOADER_PARITY_EN
      perr_q <= 1'b0;
`endif
    end else if (clr) begin
      state <= IDLE;
      sr    <= '0;
      bc    <= '0;
      load  <= 1'b0;
      busy  <= 1'b0;
`ifdef SP_LOADER_PARITY_EN
      perr_q <= 1'b0;
`endif
    end else begin
      load <= 1'b0;
      case (state)
        IDLE, SHIFT, LOAD: begin
          if (sval) begin
            sr <= shifted;
            if (cnt_now == LAST) begin
`ifdef SP_LOADER_PARITY_EN
              bc    <= BW'(n);
              busy  <= 1'b1;
              state <= PAR;
`else
              d     <= shifted;
              load  <= 1'b1;
              wcnt  <= wcnt + CW'(1);
              bc    <= '0;
              busy  <= 1'b0;
              state <= LOAD;
`endif
            end else begin
              bc    <= cnt_now + BW'(1);
              busy  <= 1'b1;
              state <= SHIFT;
            end
          end else if (state == LOAD) begin
            bc    <= '0;
            state <= IDLE;
          end
        end
`ifdef SP_LOADER_PARITY_EN
        PAR: begin
          if (sval) begin
            bc   <= '0;
            busy <= 1'b0;
            if (sin == ^sr) begin
              d     <= sr;
              load  <= 1'b1;
              wcnt  <= wcnt + CW'(1);
              state <= LOAD;
            end else begin
              perr_q <= 1'b1;
              state  <= IDLE;
            end
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sp_loader.sv
// Randomised scoreboard bench for sp_loader (n=4, CW=8), with a word-level reference model.
module tb_sp_loader;
  localparam int N  = 4;
  localparam int CW = 8;

  logic          ck = 1'b0;
  logic          rst = 1'b1;
  logic          sin = 1'b0;
  logic          sval = 1'b0;
  logic          clr = 1'b0;
  logic [N-1:0]  d;
  logic          load;
  logic          busy;
  logic [CW-1:0] wcnt;
  logic          perr;

  sp_loader #(.n(N), .CW(CW)) dut (
    .ck(ck), .rst(rst), .sin(sin), .sval(sval), .clr(clr),
    .d(d), .load(load), .busy(busy), .wcnt(wcnt), .perr(perr)
  );

  always #5 ck = ~ck;

  // Downstream register capturing on the falling edge.
  logic [N-1:0] reg_q;
  always @(negedge ck or posedge rst)
    if (rst) reg_q <= '0;
    else if (load) reg_q <= d;

  int total = 0;
  int bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: words are collected bit by bit; a full word (with
  // matching parity when enabled) is delivered on the following cycle.
  typedef struct {
    logic [N-1:0]  d;
    logic [CW-1:0] w;
  } exp_t;
  exp_t sb[$];

  logic [N-1:0]  acc;
  int            nb;
  bit            par_wait;
  logic          exp_load, exp_busy, exp_perr;
  logic [N-1:0]  exp_d;
  logic [CW-1:0] exp_wcnt;

  task automatic model_reset();
    acc = '0; nb = 0; par_wait = 0;
    exp_load = 0; exp_busy = 0; exp_perr = 0;
    exp_d = '0; exp_wcnt = '0;
    sb.delete();
  endtask

  task automatic deliver();
    exp_t e;
    exp_wcnt = exp_wcnt + 1'b1;
    exp_d    = acc;
    exp_load = 1;
    e.d = acc;
    e.w = exp_wcnt;
    sb.push_back(e);
  endtask

  task automatic model_step(input logic b, input logic v, input logic c);
    exp_load = 0;
    if (c) begin
      nb = 0; par_wait = 0; exp_perr = 0;
    end else if (v) begin
      if (par_wait) begin
        par_wait = 0;
        if (b == ^acc) deliver();
        else exp_perr = 1;
      end else begin
        acc = N'((acc << 1) | N'(b));
        nb++;
        if (nb == N) begin
          nb = 0;
`ifdef SP_LOADER_PARITY_EN
          par_wait = 1;
`else
          deliver();
`endif
        end
      end
    end
    exp_busy = (nb > 0) || par_wait;
  endtask

  // One clock: inputs applied 1 time unit after an edge, model updated at the edge.
  task automatic cyc(input logic b, input logic v, input logic c);
    sin = b; sval = v; clr = c;
    @(posedge ck);
    model_step(b, v, c);
    #1;
  endtask

  task automatic send_word(input logic [N-1:0] w, input int gap);
    for (int i = N - 1; i >= 0; i--) begin
      cyc(w[i], 1'b1, 1'b0);
      for (int g = 0; g < gap; g++) cyc(1'b0, 1'b0, 1'b0);
    end
`ifdef SP_LOADER_PARITY_EN
    cyc(^w, 1'b1, 1'b0);
`endif
  endtask

  // Monitor: compares every cycle at the falling edge and pops the scoreboard on load.
  initial begin
    exp_t e;
    forever begin
      @(negedge ck);
      check("load", load, exp_load);
      check("busy", busy, exp_busy);
      check("perr", perr, exp_perr);
      check("wcnt", wcnt, exp_wcnt);
      if (load) begin
        if (sb.size() == 0) begin
          check("unexpected_load", 1, 0);
        end else begin
          e = sb.pop_front();
          $display("load d=%b wcnt=%0d (expected d=%b wcnt=%0d)", d, wcnt, e.d, e.w);
          check("load_d", d, e.d);
          check("load_wcnt", wcnt, e.w);
          #1 check("reg_q", reg_q, e.d);
        end
      end else begin
        check("d_hold", d, exp_d);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    model_reset();
    #1;
    check("rst_d", d, 0);
    check("rst_load", load, 0);
    check("rst_busy", busy, 0);
    check("rst_wcnt", wcnt, 0);
    check("rst_perr", perr, 0);
    @(posedge ck); #1;
    @(posedge ck); #1;
    rst = 0;

    // Contiguous word
    send_word(4'b1011, 0);
    check("dir1_d", d, 4'b1011);
    check("dir1_load", load, 1);
    check("dir1_wcnt", wcnt, 1);
    cyc(0, 0, 0);
    cyc(0, 0, 0);

    // Gapped word
    send_word(4'b1011, 2);
    check("dir2_d", d, 4'b1011);
    check("dir2_wcnt", wcnt, 2);
    cyc(0, 0, 0);

    // Back-to-back words
    send_word(4'b1011, 0);
    send_word(4'b0110, 0);
    check("dir3_d", d, 4'b0110);
    check("dir3_wcnt", wcnt, 4);
    cyc(0, 0, 0);

    // Abort after two bits
    cyc(1, 1, 0);
    cyc(1, 1, 0);
    cyc(0, 0, 1);
    check("dir4_busy_after_clr", busy, 0);
    send_word(4'b0110, 0);
    check("dir4_d", d, 4'b0110);
    check("dir4_wcnt", wcnt, 5);
    cyc(0, 0, 0);

`ifdef SP_LOADER_PARITY_EN
    // Bad parity: word rejected, sticky error until clr
    cyc(1, 1, 0); cyc(0, 1, 0); cyc(1, 1, 0); cyc(1, 1, 0);
    cyc(0, 1, 0);
    check("par_perr", perr, 1);
    check("par_load", load, 0);
    check("par_d_kept", d, 4'b0110);
    check("par_wcnt_kept", wcnt, 5);
    cyc(0, 0, 0);
    check("par_perr_sticky", perr, 1);
    cyc(0, 0, 1);
    check("par_perr_cleared", perr, 0);
`endif

    // Reset mid-word between edges
    cyc(1, 1, 0);
    cyc(0, 1, 0);
    #3 rst = 1;
    model_reset();
    #1;
    check("mid_rst_d", d, 0);
    check("mid_rst_load", load, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_wcnt", wcnt, 0);
    check("mid_rst_perr", perr, 0);
    @(posedge ck); #1;
    rst = 0;
    check("mid_rst_held_busy", busy, 0);

    // Randomised traffic
    for (int i = 0; i < 4000; i++) begin
      logic v, b, c;
      v = ($urandom_range(0, 3) != 0);
      b = $urandom_range(0, 1);
      c = ($urandom_range(0, 49) == 0);
      cyc(b, v, c);
    end
    cyc(0, 0, 0);
    cyc(0, 0, 0);
    cyc(0, 0, 0);
    check("scoreboard_drained", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
